// File: rtl/team_06_lcd_controller.sv
// HD44780-compatible 16x2 character LCD sequencer, 8-bit write-only bus.
// Waits out the power-up delay, runs the four-command init sequence, then
// streams line 1 and line 2 from a shadow copy of the text rows. A new frame
// starts from IDLE whenever the live rows differ from the shadow copy or a
// refresh is forced. Every byte is SETUP (en low) -> PULSE (en high) ->
// WAIT (en low), with rs/data held for the whole byte.
module team_06_lcd_controller #(
    parameter logic [23:0] POWERUP_CYC = 24'd1_000_000,
    parameter logic [7:0]  SETUP_CYC   = 8'd4,
    parameter logic [7:0]  EN_CYC      = 8'd12,
    parameter logic [15:0] WAIT_CYC    = 16'd2_000,
    parameter logic [23:0] CLEAR_CYC   = 24'd100_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row_1,
    input  logic [127:0] row_2,
    input  logic         force_refresh,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         busy
);

    // Top-level sequencing states
    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_L1_ADDR = 3'd2;
    localparam logic [2:0] S_L1_CHAR = 3'd3;
    localparam logic [2:0] S_L2_ADDR = 3'd4;
    localparam logic [2:0] S_L2_CHAR = 3'd5;
    localparam logic [2:0] S_IDLE    = 3'd6;

    // Byte-writer phases
    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_PULSE = 2'd1;
    localparam logic [1:0] P_WAIT  = 2'd2;

    // Terminal counts: a phase lasting N cycles ends when the counter is N-1
    localparam logic [23:0] PWR_T = POWERUP_CYC - 24'd1;
    localparam logic [23:0] SET_T = {16'd0, SETUP_CYC} - 24'd1;
    localparam logic [23:0] EN_T  = {16'd0, EN_CYC} - 24'd1;
    localparam logic [23:0] WT_T  = {8'd0, WAIT_CYC} - 24'd1;
    localparam logic [23:0] CLR_T = CLEAR_CYC - 24'd1;

    logic [2:0]   state_q, state_d;
    logic [1:0]   phase_q, phase_d;
    logic [23:0]  cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] shadow1_q, shadow1_d;
    logic [127:0] shadow2_q, shadow2_d;
    logic         rs_q, rs_d;
    logic         en_q, en_d;
    logic [7:0]   data_q, data_d;
    logic         init_done_q, init_done_d;
    logic         busy_q, busy_d;
    logic [23:0]  wait_t;
    logic         byte_done;
    logic         frame_req;

    // Byte to be driven for a given state/index; characters come from the shadow rows
    function automatic logic [7:0] byte_for(input logic [2:0]   st,
                                            input logic [3:0]   idx,
                                            input logic [127:0] s1,
                                            input logic [127:0] s2);
        byte_for = 8'h00;
        case (st)
            S_INIT: begin
                case (idx)
                    4'd0:    byte_for = 8'h38;
                    4'd1:    byte_for = 8'h0C;
                    4'd2:    byte_for = 8'h06;
                    default: byte_for = 8'h01;
                endcase
            end
            S_L1_ADDR: byte_for = 8'h80;
            S_L1_CHAR: byte_for = s1[{~idx, 3'b111} -: 8];
            S_L2_ADDR: byte_for = 8'hC0;
            S_L2_CHAR: byte_for = s2[{~idx, 3'b111} -: 8];
            default:   byte_for = 8'h00;
        endcase
    endfunction

    // The clear command needs the long settle time instead of the ordinary one
    assign wait_t = (state_q == S_INIT && idx_q == 4'd3) ? CLR_T : WT_T;

    // A frame is requested from IDLE by a text change or a forced refresh
    assign frame_req = ({row_1, row_2} != {shadow1_q, shadow2_q}) || force_refresh;

    // Next-state logic: top FSM, byte-writer phases and the registered bus values
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shadow1_d   = shadow1_q;
        shadow2_d   = shadow2_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        byte_done   = 1'b0;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q >= PWR_T) begin
                    state_d = S_INIT;
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_IDLE: begin
                if (frame_req) begin
                    state_d   = S_L1_ADDR;
                    phase_d   = P_SETUP;
                    cnt_d     = '0;
                    idx_d     = '0;
                    shadow1_d = row_1;
                    shadow2_d = row_2;
                end
            end
            default: begin
                case (phase_q)
                    P_SETUP: begin
                        if (cnt_q >= SET_T) begin
                            phase_d = P_PULSE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                    P_PULSE: begin
                        if (cnt_q >= EN_T) begin
                            phase_d = P_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                    default: begin
                        if (cnt_q >= wait_t) begin
                            byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                endcase

                if (byte_done) begin
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                    case (state_q)
                        S_INIT: begin
                            if (idx_q == 4'd3) begin
                                state_d     = S_L1_ADDR;
                                idx_d       = '0;
                                init_done_d = 1'b1;
                                shadow1_d   = row_1;
                                shadow2_d   = row_2;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        S_L1_ADDR: begin
                            state_d = S_L1_CHAR;
                            idx_d   = '0;
                        end
                        S_L1_CHAR: begin
                            if (idx_q == 4'd15) begin
                                state_d = S_L2_ADDR;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        S_L2_ADDR: begin
                            state_d = S_L2_CHAR;
                            idx_d   = '0;
                        end
                        S_L2_CHAR: begin
                            if (idx_q == 4'd15) begin
                                state_d = S_IDLE;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        default: begin
                            state_d = S_POWERUP;
                            idx_d   = '0;
                        end
                    endcase
                end
            end
        endcase

        // Bus values follow the next state so every output comes straight from a flop
        busy_d = (state_d != S_IDLE);
        en_d   = 1'b0;
        if (state_d != S_POWERUP && state_d != S_IDLE) begin
            en_d   = (phase_d == P_PULSE);
            rs_d   = (state_d == S_L1_CHAR) || (state_d == S_L2_CHAR);
            data_d = byte_for(state_d, idx_d, shadow1_d, shadow2_d);
        end
    end

    // State and output registers with synchronous reset back to power-up
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_POWERUP;
            phase_q     <= P_SETUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow1_q   <= {16{8'h20}};
            shadow2_q   <= {16{8'h20}};
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow1_q   <= shadow1_d;
            shadow2_q   <= shadow2_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_data  = data_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule
